// File: rtl/cpu_pkg.sv
// Shared definitions for the core: fetch FSM state encoding and default
// instruction/address geometry.
package cpu_pkg;

    localparam int unsigned DEF_INST_WIDTH      = 32;
    localparam int unsigned DEF_INST_ADDR_WIDTH = 7;
    localparam int unsigned DEF_RESET_PC        = 0;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC = 2'd2;
    localparam logic [1:0] ST_DROP_ENC = 2'd3;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE_ENC,
        StRun  = ST_RUN_ENC,
        StWait = ST_WAIT_ENC,
        StDrop = ST_DROP_ENC
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush; head entry is presented combinationally
// from the storage registers.
module fetch_fifo #(
    parameter int unsigned WIDTH = 39,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_en;
    logic             pop_en;

    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        pop_en  = pop && !empty;
        // A pop frees the slot this cycle, so a full FIFO may still take a push.
        push_en = push && (!full || pop_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one memory request at a time and
// buffers returned instructions for decode; redirects flush everything in flight.
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned INST_WIDTH      = DEF_INST_WIDTH,
    parameter int unsigned INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned RESET_PC        = DEF_RESET_PC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       inst_we_core2mem,
    output logic                       inst_request_core2mem,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr_core2mem,
    input  logic                       inst_valid_mem2core,
    input  logic [INST_WIDTH-1:0]      inst_mem2core,
    input  logic                       redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [INST_WIDTH-1:0]      if_inst,
    output logic [INST_ADDR_WIDTH-1:0] if_pc
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [INST_ADDR_WIDTH-1:0] RST_PC  = INST_ADDR_WIDTH'(RESET_PC);
    localparam logic [INST_ADDR_WIDTH-1:0] PC_ONE  = INST_ADDR_WIDTH'(1);
    localparam logic [CNT_W-1:0]           DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e                       state_q;
    logic [INST_ADDR_WIDTH-1:0]         pc_q;
    logic [INST_ADDR_WIDTH-1:0]         addr_q;
    logic [INST_ADDR_WIDTH-1:0]         pc_inc;

    logic                               fifo_push;
    logic                               fifo_pop;
    logic                               fifo_flush;
    logic                               fifo_full;
    logic                               fifo_empty;
    logic [CNT_W-1:0]                   fifo_count;
    logic [CNT_W-1:0]                   count_after;
    logic [INST_WIDTH+INST_ADDR_WIDTH-1:0] fifo_rdata;

    always_comb begin
        pc_inc      = pc_q + PC_ONE;
        fifo_pop    = !fifo_empty && if_ready;
        fifo_flush  = redirect_valid;
        fifo_push   = (state_q == StWait) && inst_valid_mem2core && !redirect_valid;
        count_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RST_PC;
            addr_q  <= RST_PC;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end else if (start) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end else if (!fifo_full) begin
                        state_q <= StWait;
                        addr_q  <= pc_q;
                    end
                end
                StWait: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        state_q <= inst_valid_mem2core ? StRun : StDrop;
                    end else if (inst_valid_mem2core) begin
                        pc_q <= pc_inc;
                        // Back-to-back request only if the post-push/pop FIFO has room.
                        if (count_after < DEPTH_C) begin
                            addr_q <= pc_inc;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StDrop: begin
                    // Request stays up at addr_q until the stale response retires.
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                    if (inst_valid_mem2core) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH(INST_WIDTH + INST_ADDR_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({inst_mem2core, pc_q}),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inst_we_core2mem      = 1'b0;
    assign inst_request_core2mem = (state_q == StWait) || (state_q == StDrop);
    assign inst_addr_core2mem    = addr_q;
    assign if_valid              = !fifo_empty;
    assign {if_inst, if_pc}      = fifo_rdata;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: cycle table for the fill sequence, directed
// redirect/reset sequences and a randomized run against a stream-level model.
module tb_inst_fetch_unit;

    localparam int AW = 7;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          we;
    logic          req;
    logic [AW-1:0] addr;
    logic          mem_valid = 1'b0;
    logic          stray_valid = 1'b0;
    logic          inst_valid;
    logic [IW-1:0] mem_data = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          if_valid;
    logic          if_ready = 1'b0;
    logic [IW-1:0] if_inst;
    logic [AW-1:0] if_pc;

    // Second instance with a reset PC near the top of the address space.
    logic          we_w;
    logic          req_w;
    logic [AW-1:0] addr_w;
    logic          mw_valid = 1'b0;
    logic [IW-1:0] mw_data = '0;
    logic          if_valid_w;
    logic [IW-1:0] if_inst_w;
    logic [AW-1:0] if_pc_w;

    assign inst_valid = mem_valid | stray_valid;

    inst_fetch_unit dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .inst_we_core2mem      (we),
        .inst_request_core2mem (req),
        .inst_addr_core2mem    (addr),
        .inst_valid_mem2core   (inst_valid),
        .inst_mem2core         (mem_data),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .if_valid              (if_valid),
        .if_ready              (if_ready),
        .if_inst               (if_inst),
        .if_pc                 (if_pc)
    );

    inst_fetch_unit #(.RESET_PC(32'h7E)) dut_w (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .inst_we_core2mem      (we_w),
        .inst_request_core2mem (req_w),
        .inst_addr_core2mem    (addr_w),
        .inst_valid_mem2core   (mw_valid),
        .inst_mem2core         (mw_data),
        .redirect_valid        (1'b0),
        .redirect_pc           (7'h00),
        .if_valid              (if_valid_w),
        .if_ready              (1'b1),
        .if_inst               (if_inst_w),
        .if_pc                 (if_pc_w)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [AW-1:0] exp_pc = '0;
    logic          prev_redir = 1'b0;
    int            n_acc = 0;
    int            n_memv = 0;
    bit            busy = 1'b0;
    int            cnt = 0;
    int            mem_lat = 1;
    logic [AW-1:0] mem_addr = '0;
    logic [AW-1:0] req_q[$];
    bit            mw_busy = 1'b0;
    logic [AW-1:0] w_pcs[$];

    typedef struct {
        logic          req;
        logic [AW-1:0] addr;
        logic          vld;
        logic [AW-1:0] pc;
    } vec_t;

    vec_t vt[10];

    function automatic logic [IW-1:0] memword(input logic [AW-1:0] a);
        return {a, ~a, 18'h2A5A5};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: every accepted instruction must be the next sequential
    // address since the last redirect (or reset), carrying that address's word.
    task automatic monitor();
        if (!rst_n) begin
            exp_pc     = 7'h00;
            prev_redir = 1'b0;
        end else begin
            chk("we_tied_low", {31'b0, we}, 32'd0);
            chk("we_w_tied_low", {31'b0, we_w}, 32'd0);
            if (prev_redir) chk("flush_after_redirect", {31'b0, if_valid}, 32'd0);
            if (if_valid && if_ready) begin
                chk("if_pc", {25'b0, if_pc}, {25'b0, exp_pc});
                chk("if_inst", if_inst, memword(exp_pc));
                exp_pc++;
                n_acc++;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            prev_redir = redirect_valid;
            if (if_valid_w) begin
                chk("wrap_inst", if_inst_w, memword(if_pc_w));
                if (w_pcs.size() < 4) w_pcs.push_back(if_pc_w);
            end
        end
    endtask

    // Memory with configurable latency (0 selects a random 1..4 per transaction).
    task automatic mem_update();
        if (!rst_n) begin
            mem_valid = 1'b0;
            busy      = 1'b0;
        end else begin
            if (mem_valid) begin
                mem_valid = 1'b0;
                busy      = 1'b0;
            end
            if (busy) begin
                chk("req_held", {31'b0, req}, 32'd1);
                chk("addr_stable", {25'b0, addr}, {25'b0, mem_addr});
                if (cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = memword(mem_addr);
                    n_memv++;
                end else begin
                    cnt--;
                end
            end else if (req) begin
                busy     = 1'b1;
                mem_addr = addr;
                req_q.push_back(addr);
                cnt = ((mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat) - 1;
            end
        end
    endtask

    task automatic mw_update();
        if (!rst_n) begin
            mw_valid = 1'b0;
            mw_busy  = 1'b0;
        end else if (mw_valid) begin
            mw_valid = 1'b0;
            mw_busy  = req_w;
        end else if (mw_busy) begin
            mw_valid = 1'b1;
            mw_data  = memword(addr_w);
        end else begin
            mw_busy = req_w;
        end
    endtask

    // Returns at posedge+1 with inputs for the next cycle to be driven by the caller.
    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        mem_update();
        mw_update();
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return if_valid;
            1:       return req;
            default: return mem_valid;
        endcase
    endfunction

    task automatic wait_for(input int which, input int max, input string name);
        int   i;
        logic hit;
        i   = 0;
        hit = sig(which);
        while (!hit && i < max) begin
            cyc();
            i++;
            hit = sig(which);
        end
        chk(name, {31'b0, hit}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        stray_valid    = 1'b0;
        cyc();
        cyc();
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_addr", {25'b0, addr}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_pc", {25'b0, if_pc}, 32'd0);
        chk("rst_w_addr", {25'b0, addr_w}, 32'h7E);
        rst_n = 1'b1;
        cyc();
        chk("idle_req", {31'b0, req}, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        // Fill sequence at memory latency 1, decode always ready.
        vt[0] = '{1'b0, 7'h00, 1'b0, 7'h00};
        vt[1] = '{1'b1, 7'h00, 1'b0, 7'h00};
        vt[2] = '{1'b1, 7'h00, 1'b0, 7'h00};
        vt[3] = '{1'b1, 7'h01, 1'b1, 7'h00};
        vt[4] = '{1'b1, 7'h01, 1'b0, 7'h00};
        vt[5] = '{1'b1, 7'h02, 1'b1, 7'h01};
        vt[6] = '{1'b1, 7'h02, 1'b0, 7'h00};
        vt[7] = '{1'b1, 7'h03, 1'b1, 7'h02};
        vt[8] = '{1'b1, 7'h03, 1'b0, 7'h00};
        vt[9] = '{1'b1, 7'h04, 1'b1, 7'h03};

        // Test 1 + wrap instance (test 5).
        do_reset();
        w_pcs.delete();
        if_ready = 1'b1;
        mem_lat  = 1;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t1_req[%0d]", i), {31'b0, req}, {31'b0, vt[i].req});
            chk($sformatf("t1_addr[%0d]", i), {25'b0, addr}, {25'b0, vt[i].addr});
            chk($sformatf("t1_vld[%0d]", i), {31'b0, if_valid}, {31'b0, vt[i].vld});
            if (vt[i].vld) begin
                chk($sformatf("t1_pc[%0d]", i), {25'b0, if_pc}, {25'b0, vt[i].pc});
                chk($sformatf("t1_inst[%0d]", i), if_inst, memword(vt[i].pc));
            end
            cyc();
        end
        repeat (4) cyc();
        chk("wrap_count", w_pcs.size(), 32'd4);
        if (w_pcs.size() == 4) begin
            chk("wrap_pc0", {25'b0, w_pcs[0]}, 32'h7E);
            chk("wrap_pc1", {25'b0, w_pcs[1]}, 32'h7F);
            chk("wrap_pc2", {25'b0, w_pcs[2]}, 32'h00);
            chk("wrap_pc3", {25'b0, w_pcs[3]}, 32'h01);
        end

        // Test 2: decode stalled, FIFO fills to depth then fetch stops.
        do_reset();
        mem_lat = 1;
        n_memv  = 0;
        pulse_start();
        repeat (20) cyc();
        chk("stall_fetch_count", n_memv, 32'd2);
        chk("stall_req_low", {31'b0, req}, 32'd0);
        chk("stall_valid", {31'b0, if_valid}, 32'd1);
        chk("stall_head_pc", {25'b0, if_pc}, 32'd0);
        req_q.delete();
        if_ready = 1'b1;
        repeat (12) cyc();
        chk("resume_req_seen", {31'b0, (req_q.size() > 0)}, 32'd1);
        if (req_q.size() > 0) chk("resume_addr", {25'b0, req_q[0]}, 32'd2);

        // Test 3: redirect while waiting on a slow response.
        do_reset();
        mem_lat = 3;
        pulse_start();
        wait_for(0, 30, "t3_first_valid");
        chk("t3_wait_req", {31'b0, req}, 32'd1);
        chk("t3_wait_addr", {25'b0, addr}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 7'h40;
        req_q.delete();
        cyc();
        redirect_valid = 1'b0;
        chk("t3_flushed", {31'b0, if_valid}, 32'd0);
        chk("t3_drop_req", {31'b0, req}, 32'd1);
        chk("t3_drop_addr", {25'b0, addr}, 32'd1);
        if_ready = 1'b1;
        wait_for(0, 40, "t3_refetch_valid");
        chk("t3_first_pc", {25'b0, if_pc}, 32'h40);
        chk("t3_req_seen", {31'b0, (req_q.size() > 0)}, 32'd1);
        if (req_q.size() > 0) chk("t3_new_addr", {25'b0, req_q[0]}, 32'h40);

        // Test 4: redirect in the same cycle as the response.
        do_reset();
        mem_lat  = 2;
        if_ready = 1'b1;
        pulse_start();
        wait_for(2, 20, "t4_mem_valid");
        redirect_valid = 1'b1;
        redirect_pc    = 7'h20;
        req_q.delete();
        cyc();
        redirect_valid = 1'b0;
        chk("t4_no_drop", {31'b0, req}, 32'd0);
        chk("t4_not_pushed", {31'b0, if_valid}, 32'd0);
        wait_for(1, 10, "t4_req_rise");
        chk("t4_new_addr", {25'b0, addr}, 32'h20);
        wait_for(0, 20, "t4_refetch_valid");
        chk("t4_first_pc", {25'b0, if_pc}, 32'h20);

        // Test 6: asynchronous reset in the middle of a transaction.
        do_reset();
        mem_lat = 5;
        pulse_start();
        wait_for(0, 30, "t6_first_valid");
        cyc();
        cyc();
        chk("t6_pre_req", {31'b0, req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_req", {31'b0, req}, 32'd0);
        chk("t6_async_valid", {31'b0, if_valid}, 32'd0);
        cyc();
        cyc();
        #2;
        rst_n = 1'b1;
        cyc();
        stray_valid = 1'b1;
        cyc();
        stray_valid = 1'b0;
        cyc();
        chk("t6_no_stray_push", {31'b0, if_valid}, 32'd0);
        chk("t6_idle_req", {31'b0, req}, 32'd0);
        chk("t6_idle_addr", {25'b0, addr}, 32'd0);
        mem_lat  = 1;
        if_ready = 1'b1;
        n_acc    = 0;
        pulse_start();
        repeat (30) cyc();
        chk("t6_restart_fetches", {31'b0, (n_acc > 5)}, 32'd1);

        // Randomized run: random latency, stalls and redirects.
        do_reset();
        mem_lat  = 0;
        if_ready = 1'b1;
        pulse_start();
        n_acc = 0;
        for (int i = 0; i < 3000; i++) begin
            if_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(19, 0) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = AW'($urandom);
            end else begin
                redirect_valid = 1'b0;
            end
            cyc();
        end
        redirect_valid = 1'b0;
        repeat (10) cyc();
        chk("rand_throughput", {31'b0, (n_acc > 200)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
